speech_seq_ctrl: RTL and testbench

- Clock-domain sequencer for the speech recognition pipeline: receive audio frame over SPI → store samples → run matcher → return result byte to master.
- Owns frame framing (synchronised ss), the sample-buffer write port, processor start/done handshake, transmitter load handshake, and error/timeout handling.
- Sits in the top-level speech recogniser between the SPI byte receiver/transmitter and the audio-processing block.

---
 rtl/speech_pkg.sv | 12 +
 rtl/speech_seq_ctrl_if.sv | 29 ++
 rtl/sync_2ff.sv | 13 +
 rtl/speech_seq_ctrl.sv | 84 ++++++++
 tb/tb_speech_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/speech_pkg.sv
// speech_pkg: shared types and widths for the speech recogniser sequencer.
package speech_pkg;
  localparam int RESULT_W = 8;
  localparam int SAMPLE_W = 8;
  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    RECV    = 3'b001,
    PROC    = 3'b010,
    WAIT_TX = 3'b011,
    SEND    = 3'b100
  } statetype;
endpackage

// File: rtl/speech_seq_ctrl_if.sv
// speech_seq_ctrl_if: SPI byte, sample-buffer, matcher and transmitter signals of the sequencer.
interface speech_seq_ctrl_if #(
  parameter int ADDR_W = 3
);
  import speech_pkg::*;
  logic                ss;
  logic                rx_valid;
  logic [SAMPLE_W-1:0] rx_data;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [SAMPLE_W-1:0] wr_data;
  logic                proc_start;
  logic                proc_done;
  logic [RESULT_W-1:0] proc_result;
  logic                tx_load;
  logic [RESULT_W-1:0] tx_data;
  logic                tx_done;
  logic [2:0]          state;
  logic [RESULT_W-1:0] led;
  logic                error;
  modport master (
    output ss, rx_valid, rx_data, proc_done, proc_result, tx_done,
    input  wr_en, wr_addr, wr_data, proc_start, tx_load, tx_data, state, led, error
  );
  modport slave (
    input  ss, rx_valid, rx_data, proc_done, proc_result, tx_done,
    output wr_en, wr_addr, wr_data, proc_start, tx_load, tx_data, state, led, error
  );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
  end
endmodule

// File: rtl/speech_seq_ctrl.sv
// speech_seq_ctrl: frames an SPI audio burst into the sample buffer, runs the matcher
// and hands its result byte back to the transmitter.
module speech_seq_ctrl
  import speech_pkg::*;
#(
  parameter int NUM_SAMPLES  = 8,
  parameter int ADDR_W       = $clog2(NUM_SAMPLES),
  parameter int PROC_TIMEOUT = 1024,
  parameter int TMO_W        = $clog2(PROC_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  speech_seq_ctrl_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(PROC_TIMEOUT - 1);
  statetype          st, st_n;
  logic              ss_s, ss_q, ss_rise, ss_fall;
  logic [ADDR_W-1:0] cnt;
  logic [TMO_W-1:0]  tmo;
  logic              take, last, expire, err_set;
  sync_2ff u_ss_sync (.clk(clk), .reset_n(reset_n), .d(bus.ss), .q(ss_s));
  assign ss_rise   = ss_s & ~ss_q;
  assign ss_fall   = ~ss_s & ss_q;
  assign take      = (st == RECV) & bus.rx_valid;
  assign last      = take & (cnt == LAST_IDX);
  // tmo is 0 on the first PROC cycle, so the final allowed cycle sees TMO_LAST
  assign expire    = (st == PROC) & ~bus.proc_done & (tmo == TMO_LAST);
  assign bus.state = st;
  always_comb begin
    st_n    = IDLE;
    err_set = 1'b0;
    case (st)
      IDLE:    st_n = ss_rise ? RECV : IDLE;
      RECV: begin
        st_n    = last ? PROC : ss_fall ? IDLE : RECV;
        err_set = ss_fall & ~last;
      end
      PROC: begin
        st_n    = bus.proc_done ? WAIT_TX : expire ? IDLE : PROC;
        err_set = expire;
      end
      WAIT_TX: st_n = ss_rise ? SEND : WAIT_TX;
      SEND: begin
        st_n    = (bus.tx_done | ss_fall) ? IDLE : SEND;
        err_set = ss_fall & ~bus.tx_done;
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st             <= IDLE;
      ss_q           <= 1'b0;
      cnt            <= '0;
      tmo            <= '0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.proc_start <= 1'b0;
      bus.tx_load    <= 1'b0;
      bus.tx_data    <= '0;
      bus.led        <= '0;
      bus.error      <= 1'b0;
    end else begin
      st             <= st_n;
      ss_q           <= ss_s;
      cnt            <= ((st == IDLE) & ss_rise) ? '0 : (take & ~last) ? cnt + ADDR_W'(1) : cnt;
      tmo            <= (st == PROC) ? tmo + TMO_W'(1) : '0;
      bus.wr_en      <= take;
      bus.proc_start <= last;
      bus.tx_load    <= (st == WAIT_TX) & ss_rise;
      bus.error      <= ((st == IDLE) & ss_rise) ? 1'b0 : bus.error | err_set;
      if (take) begin
        bus.wr_addr <= cnt;
        bus.wr_data <= bus.rx_data;
      end
      if ((st == PROC) & bus.proc_done) begin
        bus.led     <= bus.proc_result;
        bus.tx_data <= bus.proc_result;
      end
    end
  end
endmodule

// File: tb/tb_speech_seq_ctrl.sv
// tb_speech_seq_ctrl: directed and randomized frames checked against a transaction-level
// model of what the master should observe after each step.
module tb_speech_seq_ctrl;
  localparam int N   = 8;
  localparam int TMO = 1024;
  localparam logic [2:0] S_IDLE = 3'd0, S_RECV = 3'd1, S_PROC = 3'd2, S_WAIT = 3'd3, S_SEND = 3'd4;
  logic       clk = 1'b0;
  logic       reset_n;
  int         vectors = 0, miscompares = 0;
  int         n_start = 0, n_load = 0, e_start = 0, e_load = 0;
  int         wa[$], wd[$];
  logic [7:0] last_tx = '0;
  logic [7:0] e_led = '0;
  logic [7:0] smp [N];
  speech_seq_ctrl_if #(.ADDR_W(3)) bus ();
  speech_seq_ctrl #(.NUM_SAMPLES(N), .PROC_TIMEOUT(TMO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa.push_back(int'(bus.wr_addr));
      wd.push_back(int'(bus.wr_data));
    end
    if (bus.proc_start) n_start++;
    if (bus.tx_load) begin
      n_load++;
      last_tx = bus.tx_data;
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_ss(input logic v);
    bus.ss = v;
    tick(4);
  endtask
  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick(1);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask
  task automatic done(input logic [7:0] r);
    bus.proc_done   = 1'b1;
    bus.proc_result = r;
    tick(1);
    bus.proc_done   = 1'b0;
    bus.proc_result = 8'($urandom);
  endtask
  task automatic txdone;
    bus.tx_done = 1'b1;
    tick(1);
    bus.tx_done = 1'b0;
  endtask
  task automatic new_samples;
    for (int i = 0; i < N; i++) smp[i] = 8'($urandom);
  endtask
  task automatic frame(input int k);
    for (int i = 0; i < k; i++) begin
      send(smp[i]);
      if (i < k - 1) tick($urandom_range(0, 2));
    end
  endtask
  task automatic check_writes(input string tag, input int k);
    chk({tag, "_nwr"}, wa.size(), k);
    for (int i = 0; i < k && wa.size() > 0; i++) begin
      chk({tag, "_addr"}, wa.pop_front(), i);
      chk({tag, "_data"}, wd.pop_front(), smp[i]);
    end
    wa.delete();
    wd.delete();
  endtask
  task automatic check_core(input string tag, input logic [2:0] s, input logic e);
    chk({tag, "_state"}, bus.state, s);
    chk({tag, "_error"}, bus.error, e);
    chk({tag, "_led"}, bus.led, e_led);
    chk({tag, "_starts"}, n_start, e_start);
    chk({tag, "_loads"}, n_load, e_load);
  endtask
  task automatic full_txn(input string tag, input logic [7:0] r);
    set_ss(1'b1);
    check_core({tag, "_recv"}, S_RECV, 1'b0);
    frame(N);
    e_start++;
    check_core({tag, "_proc"}, S_PROC, 1'b0);
    check_writes(tag, N);
    tick($urandom_range(0, 20));
    done(r);
    e_led = r;
    check_core({tag, "_wait"}, S_WAIT, 1'b0);
    chk({tag, "_txdata"}, bus.tx_data, r);
    set_ss(1'b0);
    check_core({tag, "_wait_lo"}, S_WAIT, 1'b0);
    set_ss(1'b1);
    e_load++;
    check_core({tag, "_send"}, S_SEND, 1'b0);
    chk({tag, "_loaded"}, last_tx, r);
    txdone;
    check_core({tag, "_end"}, S_IDLE, 1'b0);
    set_ss(1'b0);
  endtask
  initial begin
    int k;
    logic [7:0] r;
    reset_n = 1'b0;
    bus.ss = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.proc_done = 1'b0;
    bus.proc_result = '0;
    bus.tx_done = 1'b0;
    tick(2);
    check_core("rst", S_IDLE, 1'b0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    reset_n = 1'b1;
    tick(2);
    for (int i = 0; i < N; i++) smp[i] = 8'(8'h11 * (i + 1));
    full_txn("nom", 8'h5A);
    new_samples();
    set_ss(1'b1);
    frame(3);
    set_ss(1'b0);
    check_core("short", S_IDLE, 1'b1);
    check_writes("short", 3);
    set_ss(1'b1);
    check_core("short_re", S_RECV, 1'b0);
    send(smp[0]);
    check_writes("short_re", 1);
    set_ss(1'b0);
    check_core("short_re_abort", S_IDLE, 1'b1);
    repeat (3) begin
      k = $urandom_range(1, N - 1);
      new_samples();
      set_ss(1'b1);
      frame(k);
      set_ss(1'b0);
      check_core("short_rand", S_IDLE, 1'b1);
      check_writes("short_rand", k);
    end
    new_samples();
    set_ss(1'b1);
    frame(N);
    e_start++;
    check_core("tmo_entry", S_PROC, 1'b0);
    check_writes("tmo", N);
    tick(TMO - 1);
    check_core("tmo_last", S_PROC, 1'b0);
    tick(1);
    check_core("tmo_exp", S_IDLE, 1'b1);
    set_ss(1'b0);
    check_core("tmo_sticky", S_IDLE, 1'b1);
    set_ss(1'b1);
    frame(N);
    e_start++;
    check_writes("tmo2", N);
    tick(TMO - 1);
    r = 8'($urandom);
    done(r);
    e_led = r;
    check_core("tmo_done_wins", S_WAIT, 1'b0);
    set_ss(1'b0);
    set_ss(1'b1);
    e_load++;
    check_core("tmo_send", S_SEND, 1'b0);
    chk("tmo_loaded", last_tx, r);
    txdone;
    check_core("tmo_end", S_IDLE, 1'b0);
    set_ss(1'b0);
    new_samples();
    set_ss(1'b1);
    frame(N - 1);
    bus.ss = 1'b0;
    tick(2);
    send(smp[N-1]);
    e_start++;
    check_core("co_last", S_PROC, 1'b0);
    check_writes("co_last", N);
    r = 8'($urandom);
    tick($urandom_range(0, 5));
    done(r);
    e_led = r;
    set_ss(1'b1);
    e_load++;
    check_core("co_send", S_SEND, 1'b0);
    bus.ss = 1'b0;
    tick(2);
    txdone;
    check_core("co_tx", S_IDLE, 1'b0);
    new_samples();
    set_ss(1'b1);
    frame(N);
    e_start++;
    check_writes("abort", N);
    r = 8'($urandom);
    done(r);
    e_led = r;
    set_ss(1'b0);
    set_ss(1'b1);
    e_load++;
    check_core("abort_send", S_SEND, 1'b0);
    set_ss(1'b0);
    check_core("send_abort", S_IDLE, 1'b1);
    txdone;
    check_core("late_txdone", S_IDLE, 1'b1);
    new_samples();
    set_ss(1'b1);
    frame(5);
    check_writes("rst_recv", 5);
    #1 reset_n = 1'b0;
    bus.ss = 1'b0;
    #1 e_led = '0;
    check_core("rst_async_recv", S_IDLE, 1'b0);
    chk("rst_async_wr_addr", bus.wr_addr, 0);
    chk("rst_async_wr_data", bus.wr_data, 0);
    tick(1);
    reset_n = 1'b1;
    tick(3);
    set_ss(1'b1);
    frame(N);
    e_start++;
    check_writes("rst_send", N);
    r = 8'($urandom | 1);
    done(r);
    e_led = r;
    set_ss(1'b0);
    set_ss(1'b1);
    e_load++;
    check_core("rst_send_pre", S_SEND, 1'b0);
    #1 reset_n = 1'b0;
    bus.ss = 1'b0;
    #1 e_led = '0;
    check_core("rst_async_send", S_IDLE, 1'b0);
    chk("rst_async_tx_data", bus.tx_data, 0);
    tick(1);
    reset_n = 1'b1;
    tick(3);
    send(8'hA5);
    done(8'h3C);
    txdone;
    tick(2);
    check_core("spurious", S_IDLE, 1'b0);
    chk("spurious_nwr", wa.size(), 0);
    repeat (5) begin
      new_samples();
      full_txn("rnd", 8'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
